// File: rtl/bram_req_adapter.sv
// Valid/ready request front end for one port of a 1-cycle-latency BRAM.
// Every accepted request produces one response, buffered in order so consumers can backpressure.
module bram_req_adapter #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W/8-1:0] req_wmask,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_write,
  output logic [DATA_W-1:0]   resp_data,
  output logic                busy,
  output logic                bram_EN,
  output logic [DATA_W/8-1:0] bram_WE,
  output logic [ADDR_W-1:0]   bram_ADDR,
  output logic [DATA_W-1:0]   bram_DI,
  input  logic [DATA_W-1:0]   bram_DO
);

  localparam int unsigned PTR_W = $clog2(RESP_DEPTH);
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

  logic                  inflight_q, inflight_d;
  logic                  inflight_wr_q, inflight_wr_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_W-1:0]     fifo_data_q [RESP_DEPTH];
  logic [RESP_DEPTH-1:0] fifo_wr_q;

  logic             fire, push, pop;
  logic [CNT_W-1:0] outstanding;

  // Credit check looks only at registered state, so req_ready never depends on resp_ready.
  assign outstanding = count_q + CNT_W'(inflight_q);
  assign req_ready   = !reset && (outstanding < CNT_W'(RESP_DEPTH));
  assign fire        = req_valid && req_ready;
  assign push        = inflight_q;
  assign resp_valid  = (count_q != '0);
  assign pop         = resp_valid && resp_ready;
  assign busy        = (outstanding != '0);

  assign bram_EN   = fire;
  assign bram_WE   = fire ? req_wmask : '0;
  assign bram_ADDR = req_addr;
  assign bram_DI   = req_wdata;

  assign resp_data  = fifo_data_q[rptr_q];
  assign resp_write = fifo_wr_q[rptr_q];

  always_comb begin
    inflight_d    = fire;
    inflight_wr_d = fire && (req_wmask != '0);
    wptr_d        = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d        = pop ? rptr_q + PTR_W'(1) : rptr_q;
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight_q    <= 1'b0;
      inflight_wr_q <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
    end else begin
      inflight_q    <= inflight_d;
      inflight_wr_q <= inflight_wr_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count_q covers it.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data_q[wptr_q] <= inflight_wr_q ? '0 : bram_DO;
      fifo_wr_q[wptr_q]   <= inflight_wr_q;
    end
  end

endmodule

// File: tb/tb_bram_req_adapter.sv
// Directed and randomised checks of bram_req_adapter against a behavioural BRAM
// and an in-order response scoreboard.
module tb_bram_req_adapter;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned MW     = DATA_W / 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [MW-1:0]     req_wmask = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic              resp_write;
  logic [DATA_W-1:0] resp_data;
  logic              busy;
  logic              bram_EN;
  logic [MW-1:0]     bram_WE;
  logic [ADDR_W-1:0] bram_ADDR;
  logic [DATA_W-1:0] bram_DI;
  logic [DATA_W-1:0] bram_DO = '0;

  bram_req_adapter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESP_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_data(resp_data), .busy(busy),
    .bram_EN(bram_EN), .bram_WE(bram_WE), .bram_ADDR(bram_ADDR), .bram_DI(bram_DI),
    .bram_DO(bram_DO)
  );

  always #5 clock = ~clock;

  bit [DATA_W-1:0] mem     [1 << ADDR_W];
  bit [DATA_W-1:0] ref_mem [1 << ADDR_W];

  // Read-first BRAM port, one cycle of read latency.
  always @(posedge clock) begin
    if (bram_EN) begin
      bram_DO <= mem[bram_ADDR];
      for (int b = 0; b < int'(MW); b++)
        if (bram_WE[b]) mem[bram_ADDR][b*8 +: 8] <= bram_DI[b*8 +: 8];
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_pops = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic            wr;
    logic [DATA_W-1:0] data;
  } resp_t;
  resp_t exp_q [$];

  // Scoreboard: pop checks first (a response can never leave in its own accept cycle),
  // then record the accept that will happen at the coming edge.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (!bram_EN) check("we_idle", 64'(bram_WE), 64'd0);
      if (resp_valid && resp_ready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          check("resp_write", 64'(resp_write), 64'(e.wr));
          check("resp_data", resp_data, e.data);
        end
      end
      if (req_valid && req_ready) begin
        resp_t e;
        e.wr   = (req_wmask != '0);
        e.data = e.wr ? '0 : ref_mem[req_addr];
        exp_q.push_back(e);
        for (int b = 0; b < int'(MW); b++)
          if (req_wmask[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
      end
    end
  end

  task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [MW-1:0] m,
                       input logic [DATA_W-1:0] d);
    req_valid = v;
    req_addr  = a;
    req_wmask = m;
    req_wdata = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clock);
    #1;
  endtask

  initial begin
    int acc, stalls, run, w, stale, pops0, acc_n, cyc;
    logic fired;

    for (int i = 0; i < 256; i++) begin
      mem[i] = {32'hC0DE0000 | 32'(i), 32'(i) * 32'h9E3779B9};
    end
    mem[16'h0010]    = 64'h0123456789ABCDEF;
    mem[15'h7FFF]    = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    ref_mem[15'h7FFF] = '0;

    // Reset outputs, with a request held to show EN is gated.
    req_valid = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_bram_en", 64'(bram_EN), 64'd0);
    req_valid = 1'b0;
    reset = 1'b0;
    resp_ready = 1'b1;
    idle(2);

    // 1. Single read with 2-cycle latency.
    drive(1'b1, 15'h0010, 8'h00, '0);
    @(negedge clock);
    check("t1_en", 64'(bram_EN), 64'd1);
    check("t1_we", 64'(bram_WE), 64'd0);
    @(posedge clock); #1;
    drive(1'b0, '0, '0, '0);
    @(negedge clock);
    check("t1_valid_t1", 64'(resp_valid), 64'd0);
    check("t1_busy_t1", 64'(busy), 64'd1);
    @(negedge clock);
    check("t1_valid_t2", 64'(resp_valid), 64'd1);
    check("t1_write", 64'(resp_write), 64'd0);
    check("t1_data", resp_data, 64'h0123456789ABCDEF);
    idle(3);

    // 2. Masked write then read-back, back to back.
    drive(1'b1, 15'h7FFF, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clock);
    check("t2_we", 64'(bram_WE), 64'h0F);
    @(posedge clock); #1;
    drive(1'b1, 15'h7FFF, 8'h00, '0);
    @(posedge clock); #1;
    drive(1'b0, '0, '0, '0);
    @(negedge clock);
    check("t2_ack_valid", 64'(resp_valid), 64'd1);
    check("t2_ack_write", 64'(resp_write), 64'd1);
    check("t2_ack_data", resp_data, 64'd0);
    @(negedge clock);
    check("t2_rd_valid", 64'(resp_valid), 64'd1);
    check("t2_rd_write", 64'(resp_write), 64'd0);
    check("t2_rd_data", resp_data, 64'h0000_0000_FFFF_FFFF);
    idle(3);

    // 3. Backpressure: exactly RESP_DEPTH accepts, then credit returns after the first pop.
    resp_ready = 1'b0;
    drive(1'b1, 15'd20, 8'h00, '0);
    acc = 0;
    repeat (8) begin
      @(negedge clock);
      if (req_valid && req_ready) acc++;
    end
    check("t3_accepts", 64'(acc), 64'd4);
    check("t3_ready_full", 64'(req_ready), 64'd0);
    check("t3_busy_full", 64'(busy), 64'd1);
    pops0 = n_pops;
    @(posedge clock); #1;
    resp_ready = 1'b1;
    drive(1'b0, '0, '0, '0);
    @(negedge clock);
    check("t3_ready_popcyc", 64'(req_ready), 64'd0);
    @(negedge clock);
    check("t3_ready_after", 64'(req_ready), 64'd1);
    idle(6);
    check("t3_drained", 64'(n_pops - pops0), 64'd4);
    check("t3_busy_idle", 64'(busy), 64'd0);

    // 4. 100 back-to-back reads, no stalls and no response bubbles.
    stalls = 0;
    run = 0;
    pops0 = n_pops;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          drive(1'b1, ADDR_W'(i), 8'h00, '0);
          @(posedge clock); #1;
        end
        drive(1'b0, '0, '0, '0);
      end
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clock);
          if (req_valid && !req_ready) stalls++;
        end
      end
      begin
        w = 0;
        @(negedge clock);
        while (!resp_valid && w < 10) begin
          @(negedge clock);
          w++;
        end
        for (int j = 0; j < 100; j++) begin
          if (resp_valid) run++;
          @(negedge clock);
        end
      end
    join
    check("t4_stalls", 64'(stalls), 64'd0);
    check("t4_run", 64'(run), 64'd100);
    idle(4);
    check("t4_pops", 64'(n_pops - pops0), 64'd100);

    // 5. Reset with two buffered responses and one in flight.
    resp_ready = 1'b0;
    drive(1'b1, 15'd1, 8'h00, '0);
    @(posedge clock); #1;
    drive(1'b1, 15'd2, 8'h00, '0);
    @(posedge clock); #1;
    drive(1'b1, 15'd3, 8'h00, '0);
    @(posedge clock); #1;
    drive(1'b1, 15'd4, 8'h00, '0);
    check("t5_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("t5_resp_valid", 64'(resp_valid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_bram_en", 64'(bram_EN), 64'd0);
    check("t5_req_ready", 64'(req_ready), 64'd0);
    @(posedge clock); #1;
    drive(1'b0, '0, '0, '0);
    resp_ready = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    stale = 0;
    repeat (6) begin
      @(negedge clock);
      if (resp_valid || busy) stale++;
    end
    check("t5_stale", 64'(stale), 64'd0);
    check("t5_ready", 64'(req_ready), 64'd1);

    // 6. Random mixed traffic with random backpressure.
    acc_n = 0;
    cyc = 0;
    @(posedge clock); #1;
    while (acc_n < 10000 && cyc < 40000) begin
      @(negedge clock);
      fired = req_valid && req_ready;
      if (fired) acc_n++;
      @(posedge clock); #1;
      cyc++;
      if (fired || !req_valid)
        drive($urandom_range(0, 9) < 8, ADDR_W'($urandom_range(0, 255)),
              ($urandom_range(0, 1) == 1) ? MW'($urandom) : '0, {$urandom, $urandom});
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    drive(1'b0, '0, '0, '0);
    check("t6_accepts", 64'(acc_n), 64'd10000);
    resp_ready = 1'b1;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < 20) begin
      @(negedge clock);
      w++;
    end
    check("t6_left", 64'(exp_q.size()), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
